// File: rtl/spi_flash_target_if.sv
// SPI pin bundle plus the synchronous byte-memory port of the flash emulator.
// Latency: none, wiring only.
// Backpressure: none; SPI is master-paced and the memory port is fixed BRAM timing.
interface spi_flash_target_if #(
    parameter int ADDR_W = 24
);
    logic              spi_csel;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              miso_oe;
    logic              busy;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // Flash target side: consumes SPI pins and read data, drives MISO and memory requests.
    modport slave (
        input  spi_csel, spi_clk, spi_mosi, busy, rd_data,
        output spi_miso, miso_oe, rd_req, rd_addr, wr_en, wr_addr, wr_data
    );

    // SPI master plus memory side.
    modport master (
        output spi_csel, spi_clk, spi_mosi, busy, rd_data,
        input  spi_miso, miso_oe, rd_req, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/spi_flash_target.sv
// SPI mode-0 serial NOR flash emulator (RDID/RDSR/WREN/READ/PP) over a synchronous byte memory.
// Latency: SPI edges seen 3 clk after the pin; rd_req/wr_en 1 clk after the completing rise.
// Backpressure: none; memory must return rd_data 1 clk after rd_req and accept every wr_en.
module spi_flash_target #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter int          ADDR_W   = 24
) (
    input  logic              clk_48mhz,
    input  logic              reset_n,
    spi_flash_target_if.slave bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_RESP_ID = 3'd3;
    localparam logic [2:0] ST_RESP_SR = 3'd4;
    localparam logic [2:0] ST_DATA_RD = 3'd5;
    localparam logic [2:0] ST_DATA_WR = 3'd6;
    localparam logic [2:0] ST_IGNORE  = 3'd7;

    logic [1:0]        csel_q;
    logic [2:0]        sclk_q;
    logic [1:0]        mosi_q;
    logic [2:0]        state;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [7:0]        shift_in;
    logic [7:0]        shift_out;
    logic [7:0]        rd_buf;
    logic [15:0]       addr_acc;
    logic              armed;
    logic              wel;
    logic              pp_seen;
    logic              is_wr;
    logic              rd_pend;
    logic              first_load;
    logic              spi_miso;
    logic              miso_oe;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    logic              csel_s;
    logic              sclk_rise;
    logic              sclk_fall;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [23:0]       addr_full;

    assign csel_s    = csel_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign rx_byte   = {shift_in[6:0], mosi_q[1]};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign addr_full = {addr_acc, rx_byte};

    assign bus.spi_miso = spi_miso;
    assign bus.miso_oe  = miso_oe;
    assign bus.rd_req   = rd_req;
    assign bus.rd_addr  = rd_addr;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;

    // Two-flop synchronisers; csel resets low so a transfer cut by reset is not mistaken for idle.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            csel_q <= 2'b00;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            csel_q <= {csel_q[0], bus.spi_csel};
            sclk_q <= {sclk_q[1:0], bus.spi_clk};
            mosi_q <= {mosi_q[0], bus.spi_mosi};
        end
    end

    // Command FSM, bit/byte shifting, response output and memory port sequencing.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 2'd0;
            shift_in   <= 8'h00;
            shift_out  <= 8'hFF;
            rd_buf     <= 8'h00;
            addr_acc   <= 16'h0000;
            armed      <= 1'b0;
            wel        <= 1'b0;
            pp_seen    <= 1'b0;
            is_wr      <= 1'b0;
            rd_pend    <= 1'b0;
            first_load <= 1'b0;
            spi_miso   <= 1'b1;
            miso_oe    <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
        end else begin
            rd_req  <= 1'b0;
            wr_en   <= 1'b0;
            rd_pend <= rd_req;
            // Page-wrapping advance happens right after the write pulse has been seen.
            if (wr_en) begin
                wr_addr[7:0] <= wr_addr[7:0] + 8'd1;
            end
            if (csel_s) begin
                // Deselect beats any byte completing in the same cycle.
                armed    <= 1'b1;
                state    <= ST_IDLE;
                bit_cnt  <= 3'd0;
                miso_oe  <= 1'b0;
                spi_miso <= 1'b1;
                if (pp_seen) begin
                    wel     <= 1'b0;
                    pp_seen <= 1'b0;
                end
            end else begin
                if (rd_pend) begin
                    rd_buf <= bus.rd_data;
                    if (first_load) begin
                        shift_out  <= bus.rd_data;
                        first_load <= 1'b0;
                    end
                end
                if (sclk_rise && state != ST_IDLE) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    shift_in <= rx_byte;
                end
                if (sclk_fall && miso_oe) begin
                    spi_miso  <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b1};
                end
                case (state)
                    ST_IDLE: begin
                        if (armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_CMD: begin
                        if (byte_done) begin
                            byte_cnt <= 2'd0;
                            case (rx_byte)
                                8'h9F: begin
                                    state     <= ST_RESP_ID;
                                    shift_out <= JEDEC_ID[23:16];
                                    byte_cnt  <= 2'd1;
                                    miso_oe   <= 1'b1;
                                end
                                8'h05: begin
                                    state     <= ST_RESP_SR;
                                    shift_out <= {6'b0, wel, bus.busy};
                                    miso_oe   <= 1'b1;
                                end
                                8'h06: begin
                                    wel   <= 1'b1;
                                    state <= ST_IGNORE;
                                end
                                8'h03: begin
                                    is_wr <= 1'b0;
                                    state <= ST_ADDR;
                                end
                                8'h02: begin
                                    pp_seen <= 1'b1;
                                    is_wr   <= 1'b1;
                                    state   <= wel ? ST_ADDR : ST_IGNORE;
                                end
                                default: state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        if (byte_done) begin
                            addr_acc <= {addr_acc[7:0], rx_byte};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd2) begin
                                if (is_wr) begin
                                    wr_addr <= addr_full[ADDR_W-1:0];
                                    state   <= ST_DATA_WR;
                                end else begin
                                    rd_addr    <= addr_full[ADDR_W-1:0];
                                    rd_req     <= 1'b1;
                                    first_load <= 1'b1;
                                    miso_oe    <= 1'b1;
                                    state      <= ST_DATA_RD;
                                end
                            end
                        end
                    end
                    ST_RESP_ID: begin
                        if (byte_done) begin
                            case (byte_cnt)
                                2'd1:    shift_out <= JEDEC_ID[15:8];
                                2'd2:    shift_out <= JEDEC_ID[7:0];
                                default: shift_out <= 8'hFF;
                            endcase
                            if (byte_cnt != 2'd3) begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end
                    ST_RESP_SR: begin
                        if (byte_done) begin
                            shift_out <= {6'b0, wel, bus.busy};
                        end
                    end
                    ST_DATA_RD: begin
                        // Prefetch the next byte once the current one has started shifting.
                        if (sclk_rise && bit_cnt == 3'd0) begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                            rd_req  <= 1'b1;
                        end
                        if (byte_done) begin
                            shift_out <= rd_buf;
                        end
                    end
                    ST_DATA_WR: begin
                        if (byte_done) begin
                            wr_en   <= 1'b1;
                            wr_data <= rx_byte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target: drives SPI mode-0 transfers and a BRAM-like memory model.
module tb_spi_flash_target;
    logic clk_48mhz = 1'b0;
    logic reset_n   = 1'b0;
    int   checks    = 0;
    int   failures  = 0;

    spi_flash_target_if #(.ADDR_W(24)) bus ();

    spi_flash_target #(.JEDEC_ID(24'hEF4016), .ADDR_W(24)) dut (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    // Memory model: memory[a] = a[7:0], one-cycle read latency.
    logic [7:0] mem_q = 8'h00;
    always @(posedge clk_48mhz) if (bus.rd_req) mem_q <= bus.rd_addr[7:0];
    assign bus.rd_data = mem_q;

    // Request loggers.
    logic [23:0] rd_log [0:63];
    logic [23:0] wa_log [0:63];
    logic [7:0]  wd_log [0:63];
    int rd_n = 0;
    int wr_n = 0;
    always @(negedge clk_48mhz) begin
        if (bus.rd_req && rd_n < 64) begin rd_log[rd_n] = bus.rd_addr; rd_n++; end
        if (bus.wr_en && wr_n < 64) begin wa_log[wr_n] = bus.wr_addr; wd_log[wr_n] = bus.wr_data; wr_n++; end
    end

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'hFF;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = tx[7-i];
            repeat (6) @(negedge clk_48mhz);
            bus.spi_clk = 1'b1;
            rx[7-i] = bus.spi_miso;
            repeat (6) @(negedge clk_48mhz);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_start();
        @(negedge clk_48mhz);
        bus.spi_csel = 1'b0;
        repeat (6) @(negedge clk_48mhz);
    endtask

    task automatic cs_end();
        repeat (6) @(negedge clk_48mhz);
        bus.spi_csel = 1'b1;
        repeat (10) @(negedge clk_48mhz);
    endtask

    task automatic send_wren();
        logic [7:0] rx;
        cs_start();
        spi_bits(8'h06, 8, rx);
        cs_end();
    endtask

    task automatic test_reset();
        if (bus.spi_miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", bus.spi_miso); end
        checks++;
        if (bus.miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", bus.miso_oe); end
        checks++;
        if (bus.rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req got=%b exp=0", bus.rd_req); end
        checks++;
        if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
        checks++;
        if (bus.rd_addr !== 24'h0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", bus.rd_addr); end
        checks++;
        if (bus.wr_addr !== 24'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", bus.wr_addr); end
        checks++;
        if (bus.wr_data !== 8'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
        checks++;
    endtask

    task automatic test_rdid(input string tag);
        logic [7:0] rx;
        logic [7:0] exp_b [4];
        int r0, w0;
        exp_b[0] = 8'hEF; exp_b[1] = 8'h40; exp_b[2] = 8'h16; exp_b[3] = 8'hFF;
        r0 = rd_n; w0 = wr_n;
        cs_start();
        spi_bits(8'h9F, 8, rx);
        for (int b = 0; b < 4; b++) begin
            spi_bits(8'h00, 8, rx);
            checks++;
            if (rx !== exp_b[b]) begin failures++; $display("FAIL %s_byte%0d got=%h exp=%h", tag, b, rx, exp_b[b]); end
        end
        checks++;
        if (bus.miso_oe !== 1'b1) begin failures++; $display("FAIL %s_oe got=%b exp=1", tag, bus.miso_oe); end
        cs_end();
        checks++;
        if (rd_n !== r0 || wr_n !== w0) begin failures++; $display("FAIL %s_no_mem rd=%0d wr=%0d exp rd=%0d wr=%0d", tag, rd_n, wr_n, r0, w0); end
    endtask

    task automatic rdsr_expect(input string tag, input logic [7:0] exp);
        logic [7:0] rx;
        cs_start();
        spi_bits(8'h05, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_end();
        checks++;
        if (rx !== exp) begin failures++; $display("FAIL %s got=%h exp=%h", tag, rx, exp); end
    endtask

    task automatic test_pp_no_wren();
        logic [7:0] rx;
        int w0;
        w0 = wr_n;
        cs_start();
        spi_bits(8'h02, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h01, 8, rx);
        spi_bits(8'h00, 8, rx); spi_bits(8'hAA, 8, rx);
        cs_end();
        checks++;
        if (wr_n !== w0) begin failures++; $display("FAIL pp_no_wren writes got=%0d exp=0", wr_n - w0); end
        rdsr_expect("pp_no_wren_sr", 8'h00);
    endtask

    task automatic test_rdsr();
        logic [7:0] rx;
        bus.busy = 1'b1;
        send_wren();
        cs_start();
        spi_bits(8'h05, 8, rx);
        bus.busy = 1'b0;
        spi_bits(8'h00, 8, rx);
        checks++;
        if (rx !== 8'h03) begin failures++; $display("FAIL rdsr_busy got=%h exp=03", rx); end
        spi_bits(8'h00, 8, rx);
        checks++;
        if (rx !== 8'h02) begin failures++; $display("FAIL rdsr_idle got=%h exp=02", rx); end
        cs_end();
    endtask

    task automatic test_pp();
        logic [7:0] rx;
        int w0;
        w0 = wr_n;
        send_wren();
        cs_start();
        spi_bits(8'h02, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h01, 8, rx); spi_bits(8'hFF, 8, rx);
        spi_bits(8'h11, 8, rx); spi_bits(8'h22, 8, rx);
        cs_end();
        checks++;
        if (wr_n !== w0 + 2) begin failures++; $display("FAIL pp_count got=%0d exp=2", wr_n - w0); end
        else begin
            checks++;
            if (wa_log[w0] !== 24'h0001FF || wd_log[w0] !== 8'h11) begin
                failures++; $display("FAIL pp_wr0 got=%h@%h exp=11@0001ff", wd_log[w0], wa_log[w0]);
            end
            checks++;
            if (wa_log[w0+1] !== 24'h000100 || wd_log[w0+1] !== 8'h22) begin
                failures++; $display("FAIL pp_wr1 got=%h@%h exp=22@000100", wd_log[w0+1], wa_log[w0+1]);
            end
        end
        rdsr_expect("pp_wel_clear", 8'h00);
    endtask

    task automatic test_read();
        logic [7:0] rx;
        logic [7:0]  exp_b [3];
        logic [23:0] exp_a [4];
        int r0;
        exp_b[0] = 8'hFE; exp_b[1] = 8'hFF; exp_b[2] = 8'h00;
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        r0 = rd_n;
        cs_start();
        spi_bits(8'h03, 8, rx); spi_bits(8'hFF, 8, rx); spi_bits(8'hFF, 8, rx); spi_bits(8'hFE, 8, rx);
        for (int b = 0; b < 3; b++) begin
            spi_bits(8'h00, 8, rx);
            checks++;
            if (rx !== exp_b[b]) begin failures++; $display("FAIL read_byte%0d got=%h exp=%h", b, rx, exp_b[b]); end
        end
        cs_end();
        checks++;
        if (rd_n !== r0 + 4) begin failures++; $display("FAIL read_req_count got=%0d exp=4", rd_n - r0); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_log[r0+i] !== exp_a[i]) begin failures++; $display("FAIL read_addr%0d got=%h exp=%h", i, rd_log[r0+i], exp_a[i]); end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        int w0;
        w0 = wr_n;
        send_wren();
        cs_start();
        spi_bits(8'h02, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h10, 8, rx);
        spi_bits(8'h55, 8, rx);
        spi_bits(8'hAA, 5, rx);
        cs_end();
        checks++;
        if (wr_n !== w0 + 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", wr_n - w0); end
        else begin
            checks++;
            if (wa_log[w0] !== 24'h000010 || wd_log[w0] !== 8'h55) begin
                failures++; $display("FAIL abort_wr got=%h@%h exp=55@000010", wd_log[w0], wa_log[w0]);
            end
        end
        rdsr_expect("abort_wel_clear", 8'h00);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        int r0;
        cs_start();
        spi_bits(8'h03, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h20, 8, rx);
        spi_bits(8'h00, 8, rx);
        checks++;
        if (rx !== 8'h20) begin failures++; $display("FAIL midrd_byte got=%h exp=20", rx); end
        spi_bits(8'h00, 3, rx);
        @(negedge clk_48mhz);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.miso_oe !== 1'b0) begin failures++; $display("FAIL midrd_reset_oe got=%b exp=0", bus.miso_oe); end
        checks++;
        if (bus.spi_miso !== 1'b1) begin failures++; $display("FAIL midrd_reset_miso got=%b exp=1", bus.spi_miso); end
        repeat (3) @(negedge clk_48mhz);
        reset_n = 1'b1;
        r0 = rd_n;
        spi_bits(8'h00, 5, rx);
        spi_bits(8'h00, 8, rx);
        checks++;
        if (bus.miso_oe !== 1'b0 || rd_n !== r0) begin
            failures++; $display("FAIL midrd_ignored oe=%b reqs=%0d exp oe=0 reqs=0", bus.miso_oe, rd_n - r0);
        end
        cs_end();
        test_rdid("rdid_after_reset");
    endtask

    initial begin
        bus.spi_csel = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.busy     = 1'b0;
        repeat (4) @(negedge clk_48mhz);
        test_reset();
        reset_n = 1'b1;
        repeat (6) @(negedge clk_48mhz);
        test_rdid("rdid");
        test_pp_no_wren();
        test_rdsr();
        test_pp();
        test_read();
        test_abort();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
